// File: rtl/trexon_spi_pkg.sv
// Shared definitions for the SPI port arbiter: FSM state encoding and client IDs.
package trexon_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_LATCH = 3'd4
  } arb_state_e;

  localparam logic CL_EEPROM = 1'b0;
  localparam logic CL_PIXEL  = 1'b1;

endpackage

// File: rtl/spi_port_arbiter.sv
// Shares one byte-wide SPI engine between the EEPROM loader (client 0) and the
// HC595 pixel writer (client 1). Grants one byte at a time, owns the EEPROM chip
// select and the HC595 latch pulse, and aborts transfers that hang in BUSY.
module spi_port_arbiter
  import trexon_spi_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PIX_STREAK   = 4,
  parameter int LATCH_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              c0_req,
  input  logic              c0_lock,
  input  logic [DATA_W-1:0] c0_din,
  output logic              c0_valid,
  input  logic              c1_req,
  input  logic [DATA_W-1:0] c1_din,
  output logic              c1_valid,
  output logic [DATA_W-1:0] c_dout,
  output logic              eng_send_req,
  output logic [DATA_W-1:0] eng_din,
  input  logic [DATA_W-1:0] eng_dout,
  input  logic              eng_data_valid,
  input  logic              eng_processing,
  output logic              eeprom_cs,
  output logic              hc595_latch,
  output logic              owner,
  output logic              busy,
  output logic              timeout_err
);

  localparam int STREAK_W = $clog2(PIX_STREAK + 1);
  localparam int WD_W     = $clog2(TIMEOUT);
  localparam int LAT_W    = $clog2(LATCH_CYCLES + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(PIX_STREAK);
  localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(LATCH_CYCLES - 1);

  arb_state_e          state_q;
  logic                owner_q;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                lock_held_q;
  logic [WD_W-1:0]     wd_q;
  logic [LAT_W-1:0]    latch_cnt_q;
  logic [DATA_W-1:0]   eng_din_q;
  logic [DATA_W-1:0]   c_dout_q;
  logic                c0_valid_q;
  logic                c1_valid_q;
  logic                send_q;
  logic                eeprom_cs_q;
  logic                hc595_latch_q;
  logic                timeout_err_q;
  logic                dv_prev_q;

  logic                grant_vld;
  logic                grant_id;

  // Arbitration: pick the winner for this cycle and the streak value that goes with it.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_id  = CL_EEPROM;
    streak_d  = streak_q;
    if (lock_held_q) begin
      // A locked EEPROM burst keeps the bus; the pixel writer waits.
      grant_vld = c0_req;
      grant_id  = CL_EEPROM;
    end else if (c0_req && c1_req) begin
      grant_vld = 1'b1;
      grant_id  = (streak_q == STREAK_MAX) ? CL_EEPROM : CL_PIXEL;
    end else if (c0_req) begin
      grant_vld = 1'b1;
      grant_id  = CL_EEPROM;
    end else if (c1_req) begin
      grant_vld = 1'b1;
      grant_id  = CL_PIXEL;
    end

    if (grant_vld) begin
      if (grant_id == CL_EEPROM) begin
        streak_d = '0;
      end else if (c0_req && (streak_q != STREAK_MAX)) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  // Transfer FSM with all client/engine outputs registered.
  always_ff @(posedge clk or negedge nreset) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!nreset) begin
      state_q       <= ST_IDLE;
      owner_q       <= CL_EEPROM;
      streak_q      <= '0;
      lock_held_q   <= 1'b0;
      wd_q          <= '0;
      latch_cnt_q   <= '0;
      eng_din_q     <= '0;
      c_dout_q      <= '0;
      c0_valid_q    <= 1'b0;
      c1_valid_q    <= 1'b0;
      send_q        <= 1'b0;
      eeprom_cs_q   <= 1'b1;
      hc595_latch_q <= 1'b0;
      timeout_err_q <= 1'b0;
      dv_prev_q     <= 1'b0;
    end else begin
      // Continuous sampling means a done level already high on BUSY entry is not an edge.
      dv_prev_q <= eng_data_valid;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            owner_q   <= grant_id;
            streak_q  <= streak_d;
            eng_din_q <= (grant_id == CL_EEPROM) ? c0_din : c1_din;
            if (grant_id == CL_EEPROM) begin
              eeprom_cs_q <= 1'b0;
            end
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!eng_processing) begin
            send_q  <= 1'b1;
            wd_q    <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          send_q <= 1'b0;
          if (eng_data_valid && !dv_prev_q) begin
            c_dout_q <= eng_dout;
            if (owner_q == CL_PIXEL) begin
              c1_valid_q <= 1'b1;
            end else begin
              c0_valid_q <= 1'b1;
            end
            state_q <= ST_DONE;
          end else if (wd_q == WD_LAST) begin
            // Hung engine: release the EEPROM and drop any burst lock.
            timeout_err_q <= 1'b1;
            eeprom_cs_q   <= 1'b1;
            lock_held_q   <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_DONE: begin
          c0_valid_q <= 1'b0;
          c1_valid_q <= 1'b0;
          if (owner_q == CL_PIXEL) begin
            hc595_latch_q <= 1'b1;
            latch_cnt_q   <= '0;
            state_q       <= ST_LATCH;
          end else begin
            lock_held_q <= c0_lock;
            if (!c0_lock) begin
              eeprom_cs_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        ST_LATCH: begin
          if (latch_cnt_q == LAT_LAST) begin
            hc595_latch_q <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            latch_cnt_q <= latch_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign c0_valid     = c0_valid_q;
  assign c1_valid     = c1_valid_q;
  assign c_dout       = c_dout_q;
  assign eng_send_req = send_q;
  assign eng_din      = eng_din_q;
  assign eeprom_cs    = eeprom_cs_q;
  assign hc595_latch  = hc595_latch_q;
  assign owner        = owner_q;
  assign busy         = (state_q != ST_IDLE);
  assign timeout_err  = timeout_err_q;

endmodule
